// File: rtl/qk_inst_sequencer.sv
// Generates the complete fullchip instruction/control stream: Q write, K write, K load,
// execute, ofifo->pmem, accumulate and normalize write-back. Every output is a flop.
module qk_inst_sequencer #(
  parameter int bw          = 8,
  parameter int pr          = 16,
  parameter int col         = 8,
  parameter int total_cycle = 8,
  parameter int gap_cycles  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [pr*bw-1:0]  in_data_core1,
  input  logic [pr*bw-1:0]  in_data_core2,
  output logic [pr*bw-1:0]  mem_in_core1,
  output logic [pr*bw-1:0]  mem_in_core2,
  output logic [16:0]       inst,
  output logic              acc,
  output logic              div,
  output logic              wr_norm,
  output logic              fifo_ext_rd,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    S_IDLE, S_QWR, S_KWR, S_KGAP, S_LOAD, S_LGAP,
    S_EXEC, S_EGAP, S_OF2P, S_ACC, S_NORM, S_DONE
  } state_t;

  localparam logic [15:0] TC        = 16'(total_cycle);
  localparam logic [15:0] TC_LAST   = 16'(total_cycle - 1);
  localparam logic [15:0] COL       = 16'(col);
  localparam logic [15:0] COL_LAST  = 16'(col - 1);
  localparam logic [15:0] LOAD_LAST = 16'(col + 2);
  localparam logic [15:0] GAP_LAST  = 16'(gap_cycles - 1);
  localparam logic [15:0] NORM_LAST = 16'(2 * total_cycle - 1);
  // KGAP spans the cycle presenting the last K beat plus two clean idle cycles.
  localparam logic [15:0] KGAP_LAST = 16'd2;

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] nxt;
  logic        ofifo_rd, execute, load;
  logic        qmem_rd, qmem_wr, kmem_rd, kmem_wr, pmem_rd, pmem_wr;
  logic [3:0]  qk_add, pmem_add;

  assign nxt  = cnt + 16'd1;
  assign inst = {ofifo_rd, qk_add, pmem_add, execute, load,
                 qmem_rd, qmem_wr, kmem_rd, kmem_wr, pmem_rd, pmem_wr};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      in_ready     <= 1'b0;
      mem_in_core1 <= '0;
      mem_in_core2 <= '0;
      {ofifo_rd, execute, load, qmem_rd, qmem_wr} <= '0;
      {kmem_rd, kmem_wr, pmem_rd, pmem_wr}        <= '0;
      {acc, div, wr_norm, fifo_ext_rd}            <= '0;
      qk_add       <= '0;
      pmem_add     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      // Every cycle starts from an all-quiet instruction word; states raise what they need.
      {ofifo_rd, execute, load, qmem_rd, qmem_wr} <= '0;
      {kmem_rd, kmem_wr, pmem_rd, pmem_wr}        <= '0;
      {acc, div, wr_norm, fifo_ext_rd, done}      <= '0;
      qk_add       <= '0;
      pmem_add     <= '0;
      mem_in_core1 <= '0;
      mem_in_core2 <= '0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_QWR;
            cnt      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end

        S_QWR: begin
          qk_add       <= qk_add;
          mem_in_core1 <= mem_in_core1;
          mem_in_core2 <= mem_in_core2;
          if (in_valid && in_ready) begin
            qmem_wr      <= 1'b1;
            qk_add       <= cnt[3:0];
            mem_in_core1 <= in_data_core1;
            mem_in_core2 <= in_data_core1;
            if (cnt == TC_LAST) begin
              state <= S_KWR;
              cnt   <= '0;
            end else begin
              cnt <= nxt;
            end
          end
        end

        S_KWR: begin
          qk_add       <= qk_add;
          mem_in_core1 <= mem_in_core1;
          mem_in_core2 <= mem_in_core2;
          if (in_valid && in_ready) begin
            kmem_wr      <= 1'b1;
            qk_add       <= cnt[3:0];
            mem_in_core1 <= in_data_core1;
            mem_in_core2 <= in_data_core2;
            if (cnt == COL_LAST) begin
              state    <= S_KGAP;
              cnt      <= '0;
              in_ready <= 1'b0;
            end else begin
              cnt <= nxt;
            end
          end
        end

        S_KGAP: begin
          if (cnt == KGAP_LAST) begin
            state <= S_LOAD;
            cnt   <= '0;
            load  <= 1'b1;
          end else begin
            cnt <= nxt;
          end
        end

        S_LOAD: begin
          if (cnt == LOAD_LAST) begin
            state <= S_LGAP;
            cnt   <= '0;
          end else begin
            cnt <= nxt;
            if (nxt <= COL) begin
              load    <= 1'b1;
              kmem_rd <= 1'b1;
              qk_add  <= cnt[3:0];
            end else if (nxt == COL + 16'd1) begin
              load <= 1'b1;
            end
          end
        end

        S_LGAP: begin
          if (cnt == GAP_LAST) begin
            state   <= S_EXEC;
            cnt     <= '0;
            execute <= 1'b1;
            qmem_rd <= 1'b1;
          end else begin
            cnt <= nxt;
          end
        end

        S_EXEC: begin
          if (cnt == TC_LAST) begin
            state <= S_EGAP;
            cnt   <= '0;
          end else begin
            cnt     <= nxt;
            execute <= 1'b1;
            qmem_rd <= 1'b1;
            qk_add  <= nxt[3:0];
          end
        end

        S_EGAP: begin
          if (cnt == GAP_LAST) begin
            state    <= S_OF2P;
            cnt      <= '0;
            ofifo_rd <= 1'b1;
            pmem_wr  <= 1'b1;
          end else begin
            cnt <= nxt;
          end
        end

        S_OF2P: begin
          if (cnt == TC_LAST) begin
            // First ACC cycle is a bare prefetch of row 0, acc still low.
            state   <= S_ACC;
            cnt     <= '0;
            pmem_rd <= 1'b1;
          end else begin
            cnt      <= nxt;
            ofifo_rd <= 1'b1;
            pmem_wr  <= 1'b1;
            pmem_add <= nxt[3:0];
          end
        end

        S_ACC: begin
          if (cnt == TC) begin
            state       <= S_NORM;
            cnt         <= '0;
            wr_norm     <= 1'b1;
            pmem_rd     <= 1'b1;
            div         <= 1'b1;
            fifo_ext_rd <= 1'b1;
          end else begin
            cnt      <= nxt;
            pmem_rd  <= 1'b1;
            acc      <= 1'b1;
            pmem_add <= cnt[3:0];
          end
        end

        S_NORM: begin
          if (cnt == NORM_LAST) begin
            state <= S_DONE;
            cnt   <= '0;
            done  <= 1'b1;
          end else begin
            // Even step reads/divides row r, odd step writes it back.
            cnt      <= nxt;
            wr_norm  <= 1'b1;
            pmem_add <= nxt[4:1];
            if (!nxt[0]) begin
              pmem_rd     <= 1'b1;
              div         <= 1'b1;
              fifo_ext_rd <= 1'b1;
            end else begin
              pmem_wr <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qk_inst_sequencer.sv
// Directed bench: cycle-by-cycle expected instruction schedule built from the timeline
// of each phase, plus reset-mid-run and ignored-start scenarios.
module tb_qk_inst_sequencer;

  localparam int BW  = 8;
  localparam int PR  = 16;
  localparam int COL = 8;
  localparam int TC  = 8;
  localparam int GAP = 10;
  localparam int MW  = PR * BW;

  localparam int B_OF = 16, B_EX = 7, B_LD = 6, B_QRD = 5, B_QWR = 4;
  localparam int B_KRD = 3, B_KWR = 2, B_PRD = 1, B_PWR = 0;

  typedef logic [MW-1:0] wide_t;

  typedef struct packed {
    logic [16:0] inst;
    logic        rdy;
    logic [3:0]  nc;     // {acc, div, wr_norm, fifo_ext_rd}
    logic        done;
    logic        busy;
    wide_t       m1;
    wide_t       m2;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  wide_t       in_data_core1 = '0;
  wide_t       in_data_core2 = '0;
  logic        in_ready;
  wide_t       mem_in_core1, mem_in_core2;
  logic [16:0] inst;
  logic        acc, div, wr_norm, fifo_ext_rd, busy, done;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  qk_inst_sequencer #(
    .bw(BW), .pr(PR), .col(COL), .total_cycle(TC), .gap_cycles(GAP)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data_core1(in_data_core1), .in_data_core2(in_data_core2),
    .mem_in_core1(mem_in_core1), .mem_in_core2(mem_in_core2), .inst(inst),
    .acc(acc), .div(div), .wr_norm(wr_norm), .fifo_ext_rd(fifo_ext_rd),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input wide_t got, input wide_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic wide_t f1(int s);
    wide_t v;
    for (int j = 0; j < PR; j++) v[j*BW +: BW] = 8'(s * 7 + j + 1);
    return v;
  endfunction

  function automatic wide_t f2(int s);
    wide_t v;
    for (int j = 0; j < PR; j++) v[j*BW +: BW] = 8'(s * 11 + j + 128);
    return v;
  endfunction

  function automatic bit valid_at(bit stall, int s);
    return !(stall && s >= 3 && s <= 5);
  endfunction

  task automatic push(input logic [16:0] i, input logic [3:0] nc, input logic dn, input logic bz);
    exp_t e;
    e      = '0;
    e.inst = i;
    e.nc   = nc;
    e.done = dn;
    e.busy = bz;
    exp_q.push_back(e);
  endtask

  task automatic build(input bit stall);
    exp_t        e;
    int          nb;
    int          s;
    logic [16:0] w;
    exp_q.delete();
    e = '0; e.rdy = 1'b1; e.busy = 1'b1;
    exp_q.push_back(e);
    nb = 0; s = 0;
    while (nb < TC + COL) begin
      e = '0; e.busy = 1'b1;
      e.inst[15:12] = exp_q[s].inst[15:12];
      if (valid_at(stall, s)) begin
        e.inst[15:12] = 4'(nb < TC ? nb : nb - TC);
        e.m1 = f1(s);
        e.m2 = (nb < TC) ? f1(s) : f2(s);
        if (nb < TC) e.inst[B_QWR] = 1'b1;
        else         e.inst[B_KWR] = 1'b1;
        nb++;
      end
      e.rdy = (nb < TC + COL);
      exp_q.push_back(e);
      s++;
    end
    repeat (2) push('0, 4'b0000, 1'b0, 1'b1);
    w = '0; w[B_LD] = 1'b1; push(w, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < COL; i++) begin
      w = '0; w[B_LD] = 1'b1; w[B_KRD] = 1'b1; w[15:12] = 4'(i);
      push(w, 4'b0000, 1'b0, 1'b1);
    end
    w = '0; w[B_LD] = 1'b1; push(w, 4'b0000, 1'b0, 1'b1);
    push('0, 4'b0000, 1'b0, 1'b1);
    repeat (GAP) push('0, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < TC; i++) begin
      w = '0; w[B_EX] = 1'b1; w[B_QRD] = 1'b1; w[15:12] = 4'(i);
      push(w, 4'b0000, 1'b0, 1'b1);
    end
    repeat (GAP) push('0, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < TC; i++) begin
      w = '0; w[B_OF] = 1'b1; w[B_PWR] = 1'b1; w[11:8] = 4'(i);
      push(w, 4'b0000, 1'b0, 1'b1);
    end
    w = '0; w[B_PRD] = 1'b1; push(w, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < TC; i++) begin
      w = '0; w[B_PRD] = 1'b1; w[11:8] = 4'(i);
      push(w, 4'b1000, 1'b0, 1'b1);
    end
    for (int r = 0; r < TC; r++) begin
      w = '0; w[B_PRD] = 1'b1; w[11:8] = 4'(r);
      push(w, 4'b0111, 1'b0, 1'b1);
      w = '0; w[B_PWR] = 1'b1; w[11:8] = 4'(r);
      push(w, 4'b0010, 1'b0, 1'b1);
    end
    push('0, 4'b0000, 1'b1, 1'b1);
    repeat (3) push('0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic run_seq(input bit stall, input int restart_seg, input string nm);
    exp_t e;
    int   first_done;
    build(stall);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    first_done = -1;
    for (int s = 0; s < exp_q.size(); s++) begin
      e = exp_q[s];
      check($sformatf("%s inst@%0d", nm, s), wide_t'(inst), wide_t'(e.inst));
      check($sformatf("%s in_ready@%0d", nm, s), wide_t'(in_ready), wide_t'(e.rdy));
      check($sformatf("%s norm_ctl@%0d", nm, s),
            wide_t'({acc, div, wr_norm, fifo_ext_rd}), wide_t'(e.nc));
      check($sformatf("%s done@%0d", nm, s), wide_t'(done), wide_t'(e.done));
      check($sformatf("%s busy@%0d", nm, s), wide_t'(busy), wide_t'(e.busy));
      if (e.inst[B_QWR] || e.inst[B_KWR]) begin
        check($sformatf("%s mem1@%0d", nm, s), mem_in_core1, e.m1);
        check($sformatf("%s mem2@%0d", nm, s), mem_in_core2, e.m2);
      end
      check($sformatf("%s mutex@%0d", nm, s),
            wide_t'($countones(inst[5:0]) <= 1), wide_t'(1'b1));
      if (done && first_done < 0) first_done = s;
      in_valid      = valid_at(stall, s);
      in_data_core1 = f1(s);
      in_data_core2 = f2(s);
      start         = (s == restart_seg);
      @(negedge clk);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check({nm, " done_cycle"}, wide_t'(first_done), wide_t'(stall ? 94 : 91));
  endtask

  task automatic reset_mid_exec();
    int pulses;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int s = 0; s < 43; s++) begin
      in_valid      = 1'b1;
      in_data_core1 = f1(s);
      in_data_core2 = f2(s);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("rst exec3 inst", wide_t'(inst), wide_t'(17'h030A0));
    reset = 1'b0;
    @(negedge clk);
    check("rst inst", wide_t'(inst), '0);
    check("rst busy", wide_t'(busy), '0);
    check("rst done", wide_t'(done), '0);
    check("rst in_ready", wide_t'(in_ready), '0);
    check("rst mem1", mem_in_core1, '0);
    reset  = 1'b1;
    pulses = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("rst no done", wide_t'(pulses), '0);
    check("rst idle busy", wide_t'(busy), '0);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset inst", wide_t'(inst), '0);
    check("reset in_ready", wide_t'(in_ready), '0);
    check("reset busy", wide_t'(busy), '0);
    check("reset done", wide_t'(done), '0);
    check("reset mem1", mem_in_core1, '0);
    check("reset mem2", mem_in_core2, '0);
    check("reset norm_ctl", wide_t'({acc, div, wr_norm, fifo_ext_rd}), '0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle busy", wide_t'(busy), '0);
    run_seq(1'b0, -1, "plain");
    repeat (3) @(negedge clk);
    run_seq(1'b1, -1, "stall");
    run_seq(1'b0, 70, "start_in_acc");
    reset_mid_exec();
    run_seq(1'b0, -1, "rerun");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, failures so far %0d", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
